// File: rtl/vector_to_angle.sv
// Converts a signed direction vector (dx, dy) into an upper-half-plane heading
// in degrees by scanning k = 0..90 one candidate per clock.
module vector_to_angle #(
    parameter int W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic signed [W-1:0] dx,
    input  logic signed [W-1:0] dy,
    output logic                busy,
    output logic                done,
    output logic [8:0]          angle,
    output logic [31:0]         h_mag,
    output logic [31:0]         v_mag,
    output logic                zero_vec,
    output logic                below
);

    localparam int EW = W + 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_FINISH = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // round(1000*sin(k deg)) for k = 0..90
    function automatic logic [9:0] sin_rom(input logic [6:0] k);
        logic [9:0] s;
        case (k)
            7'd0:  s = 10'd0;
            7'd1:  s = 10'd17;
            7'd2:  s = 10'd35;
            7'd3:  s = 10'd52;
            7'd4:  s = 10'd70;
            7'd5:  s = 10'd87;
            7'd6:  s = 10'd105;
            7'd7:  s = 10'd122;
            7'd8:  s = 10'd139;
            7'd9:  s = 10'd156;
            7'd10: s = 10'd174;
            7'd11: s = 10'd191;
            7'd12: s = 10'd208;
            7'd13: s = 10'd225;
            7'd14: s = 10'd242;
            7'd15: s = 10'd259;
            7'd16: s = 10'd276;
            7'd17: s = 10'd292;
            7'd18: s = 10'd309;
            7'd19: s = 10'd326;
            7'd20: s = 10'd342;
            7'd21: s = 10'd358;
            7'd22: s = 10'd375;
            7'd23: s = 10'd391;
            7'd24: s = 10'd407;
            7'd25: s = 10'd423;
            7'd26: s = 10'd438;
            7'd27: s = 10'd454;
            7'd28: s = 10'd469;
            7'd29: s = 10'd485;
            7'd30: s = 10'd500;
            7'd31: s = 10'd515;
            7'd32: s = 10'd530;
            7'd33: s = 10'd545;
            7'd34: s = 10'd559;
            7'd35: s = 10'd574;
            7'd36: s = 10'd588;
            7'd37: s = 10'd602;
            7'd38: s = 10'd616;
            7'd39: s = 10'd629;
            7'd40: s = 10'd643;
            7'd41: s = 10'd656;
            7'd42: s = 10'd669;
            7'd43: s = 10'd682;
            7'd44: s = 10'd695;
            7'd45: s = 10'd707;
            7'd46: s = 10'd719;
            7'd47: s = 10'd731;
            7'd48: s = 10'd743;
            7'd49: s = 10'd755;
            7'd50: s = 10'd766;
            7'd51: s = 10'd777;
            7'd52: s = 10'd788;
            7'd53: s = 10'd799;
            7'd54: s = 10'd809;
            7'd55: s = 10'd819;
            7'd56: s = 10'd829;
            7'd57: s = 10'd839;
            7'd58: s = 10'd848;
            7'd59: s = 10'd857;
            7'd60: s = 10'd866;
            7'd61: s = 10'd875;
            7'd62: s = 10'd883;
            7'd63: s = 10'd891;
            7'd64: s = 10'd899;
            7'd65: s = 10'd906;
            7'd66: s = 10'd914;
            7'd67: s = 10'd921;
            7'd68: s = 10'd927;
            7'd69: s = 10'd934;
            7'd70: s = 10'd940;
            7'd71: s = 10'd946;
            7'd72: s = 10'd951;
            7'd73: s = 10'd956;
            7'd74: s = 10'd961;
            7'd75: s = 10'd966;
            7'd76: s = 10'd970;
            7'd77: s = 10'd974;
            7'd78: s = 10'd978;
            7'd79: s = 10'd982;
            7'd80: s = 10'd985;
            7'd81: s = 10'd988;
            7'd82: s = 10'd990;
            7'd83: s = 10'd993;
            7'd84: s = 10'd995;
            7'd85: s = 10'd996;
            7'd86: s = 10'd998;
            7'd87: s = 10'd999;
            7'd88: s = 10'd999;
            7'd89: s = 10'd1000;
            7'd90: s = 10'd1000;
            default: s = 10'd0;
        endcase
        return s;
    endfunction

    state_t         state_r;
    state_t         state_next_s;
    logic [W-1:0]   ax_r;
    logic [W-1:0]   ay_r;
    logic           sx_r;
    logic [6:0]     k_r;
    logic [6:0]     best_k_r;
    logic [EW-1:0]  best_err_r;
    logic           busy_r;
    logic           done_r;
    logic [8:0]     angle_r;
    logic [31:0]    h_mag_r;
    logic [31:0]    v_mag_r;
    logic           zero_vec_r;
    logic           below_r;

    logic [W-1:0]   dx_u_s;
    logic [W-1:0]   dy_u_s;
    logic [W-1:0]   dx_abs_s;
    logic [EW-1:0]  prod_c_s;
    logic [EW-1:0]  prod_s_s;
    logic [EW-1:0]  err_s;
    logic [9:0]     best_s_s;
    logic [9:0]     best_c_s;
    logic [8:0]     angle_s;

    // Operand magnitudes; the most negative input maps to 2^(W-1) unsigned
    always_comb begin
        dx_u_s   = dx;
        dy_u_s   = dy;
        dx_abs_s = dx[W-1] ? ((~dx_u_s) + {{(W-1){1'b0}}, 1'b1}) : dx_u_s;
    end

    // Cross-product error for the current candidate, full width
    always_comb begin
        prod_c_s = {{11{1'b0}}, ay_r} * {{(W+1){1'b0}}, sin_rom(7'd90 - k_r)};
        prod_s_s = {{11{1'b0}}, ax_r} * {{(W+1){1'b0}}, sin_rom(k_r)};
        err_s    = (prod_c_s >= prod_s_s) ? (prod_c_s - prod_s_s) : (prod_s_s - prod_c_s);
    end

    // Final result from the winning candidate
    always_comb begin
        best_s_s = sin_rom(best_k_r);
        best_c_s = sin_rom(7'd90 - best_k_r);
        angle_s  = sx_r ? (9'd180 - {2'b00, best_k_r}) : {2'b00, best_k_r};
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_SEARCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (k_r == 7'd90) begin
                    state_next_s = ST_FINISH;
                end else begin
                    state_next_s = ST_SEARCH;
                end
            end
            ST_FINISH: state_next_s = ST_DONE;
            ST_DONE:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Search datapath and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            ax_r       <= {W{1'b0}};
            ay_r       <= {W{1'b0}};
            sx_r       <= 1'b0;
            k_r        <= 7'd0;
            best_k_r   <= 7'd0;
            best_err_r <= {EW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            angle_r    <= 9'd0;
            h_mag_r    <= 32'd0;
            v_mag_r    <= 32'd0;
            zero_vec_r <= 1'b0;
            below_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        ax_r       <= dx_abs_s;
                        sx_r       <= dx[W-1];
                        ay_r       <= dy[W-1] ? {W{1'b0}} : dy_u_s;
                        below_r    <= dy[W-1];
                        zero_vec_r <= (dx_u_s == {W{1'b0}}) && (dy_u_s == {W{1'b0}});
                        k_r        <= 7'd0;
                        best_k_r   <= 7'd0;
                        best_err_r <= {EW{1'b1}};
                        busy_r     <= 1'b1;
                    end
                end
                ST_SEARCH: begin
                    // strict compare keeps the smaller k on ties
                    if (err_s < best_err_r) begin
                        best_err_r <= err_s;
                        best_k_r   <= k_r;
                    end
                    if (k_r != 7'd90) begin
                        k_r <= k_r + 7'd1;
                    end
                end
                ST_FINISH: begin
                    done_r <= 1'b1;
                    if (zero_vec_r) begin
                        angle_r <= 9'd90;
                        h_mag_r <= 32'd0;
                        v_mag_r <= 32'd1000;
                    end else begin
                        angle_r <= angle_s;
                        h_mag_r <= {22'd0, best_c_s};
                        v_mag_r <= {22'd0, best_s_s};
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign angle    = angle_r;
    assign h_mag    = h_mag_r;
    assign v_mag    = v_mag_r;
    assign zero_vec = zero_vec_r;
    assign below    = below_r;

endmodule

// File: doc/vector_to_angle.md
Name: vector_to_angle

Overview:
- Inverse of the heading-to-trig lookup: converts a signed direction vector (dx, dy) into an integer heading in degrees, 0..180.
- Also returns the matching ×1000 component magnitudes, so a result fed back into the trig lookup reproduces consistent velocity components.
- Sits between the target-tracking logic and the missile motion update; launches are upper-half-plane only.
- Iterative: one candidate angle is evaluated per clock, with a start/busy/done handshake.

Parameters:
- W, 16, width of signed two's-complement inputs dx and dy.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request conversion; sampled only in IDLE
- dx  in  W  signed horizontal component (+ = right)
- dy  in  W  signed vertical component (+ = up)
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse; results valid from this cycle on
- angle  out  9  heading in degrees, 0..180; 0 = +x, 90 = +y, 180 = −x
- h_mag  out  32  round(1000·|cos(angle°)|)
- v_mag  out  32  round(1000·sin(angle°))
- zero_vec  out  1  dx = dy = 0 on the accepted request
- below  out  1  dy < 0 on the accepted request (clamped)

Behaviour:
- Internal ROM: S(k) = round(1000·sin(k°)) for k = 0..90, 10-bit unsigned. C(k) = S(90−k). Example entries: S(1)=17, S(30)=500, S(45)=707, S(60)=866, S(90)=1000.
- Reset: state IDLE; busy=0, done=0, angle=0, h_mag=0, v_mag=0, zero_vec=0, below=0; search registers cleared.
- Reset asserted mid-search aborts immediately. No done is issued, and the same reset values apply.
- IDLE:
  - On start=1, latch ax=|dx|, sx=(dx<0).
  - Latch ay=|dy| if dy≥0, else ay=0 with below=1.
  - Latch zero_vec=(dx==0 && dy==0).
  - Set k=0, best_err=all-ones, best_k=0, and go to SEARCH. busy=1 from the next cycle.
  - |−2^(W−1)| is held as an unsigned W-bit value; no overflow.
- SEARCH, one k per cycle, k = 0..90 (91 cycles):
  - err = |ay·C(k) − ax·S(k)|, computed unsigned at W+11 bits; no truncation.
  - If err < best_err (strict), then best_err=err and best_k=k. Ties keep the smaller k.
  - After k=90 is evaluated, go to DONE.
- DONE (one cycle):
  - done=1 and busy=1.
  - angle = sx ? 180−best_k : best_k.
  - h_mag = C(best_k), v_mag = S(best_k).
  - If zero_vec, force angle=90, h_mag=0, v_mag=1000.
  - Next state IDLE; busy=0 the following cycle.
- Latency: start sampled at edge E0, done high in the cycle after edge E92, back in IDLE after E93.
- Outputs angle, h_mag, v_mag, zero_vec and below hold their values until the next accepted request's DONE cycle. zero_vec and below update at acceptance.
- start while busy is ignored; it is not queued.
- start held high continuously: a new request is accepted on the first IDLE cycle after DONE.
- dx and dy are sampled only at acceptance; changes during SEARCH have no effect.
- Axis cases:
  - dy=0, dx>0 → angle 0.
  - dy=0, dx<0 → angle 180.
  - dx=0, dy>0 → angle 90. ax=0 gives err = ay·C(k); the minimum is at k=90 where C=0.
- Output is combinational-free: every output is a register.

Test Plan:
- reset, then dx=100, dy=0, start → done 92 cycles after acceptance; angle=0, h_mag=1000, v_mag=0, zero_vec=0, below=0.
- dx=866, dy=500 → angle=30, h_mag=866, v_mag=500. Then dx=0, dy=50 → angle=90, h_mag=0, v_mag=1000.
- dx=−100, dy=100 → angle=135, h_mag=707, v_mag=707. Then dx=−32768, dy=0 (W=16) → angle=180, h_mag=1000, v_mag=0.
- dx=0, dy=0 → angle=90, v_mag=1000, zero_vec=1. Then dx=10, dy=−5 → below=1, angle=0.
- pulse start again 20 cycles into a search → ignored, single done at the original cycle. Hold start high → back-to-back requests, done spaced 94 cycles apart.
- assert reset at SEARCH k=40 → next cycle busy=0, done=0, angle=0. No done pulse follows; a fresh request then completes normally.
